// File: rtl/spi_frame_master.sv
// SPI initiator: shifts out a {cmd, payload} frame on SS_n/MOSI and, for read-data
// commands, waits RD_WAIT cycles then captures an 8-bit MISO reply.
//
// state    | meaning
// ST_IDLE  | SS_n high, waiting for start
// ST_CHK   | first SS_n-low cycle, MOSI shows cmd[1] (slave command check)
// ST_SHIFT | ten frame bits out on MOSI, MSB first
// ST_TURN  | read-data turnaround, RD_WAIT cycles
// ST_RECV  | eight MISO bits captured, MSB first
// ST_FIN   | SS_n high for GAP cycles; done pulses in the first one
module spi_frame_master #(
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK,
    ST_SHIFT,
    ST_TURN,
    ST_RECV,
    ST_FIN
  } state_t;

  localparam logic [3:0] RD_WAIT_M1 = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_M1     = 4'(GAP - 1);

  state_t      state, state_nxt;
  logic        accept;
  logic [9:0]  frame_q;
  logic [3:0]  bit_cnt;
  logic [3:0]  wait_cnt;
  logic [7:0]  cap_q;
  logic [7:0]  rdata_q;
  logic        rd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      frame_q  <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      cap_q    <= '0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        frame_q <= {cmd, wdata};
        rd_q    <= (cmd == 2'b11);
        bit_cnt <= '0;
      end
      case (state)
        ST_SHIFT: begin
          frame_q <= {frame_q[8:0], 1'b0};
          if (bit_cnt == 4'd9) begin
            bit_cnt  <= '0;
            wait_cnt <= rd_q ? RD_WAIT_M1 : GAP_M1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        ST_TURN: wait_cnt <= wait_cnt - 4'd1;
        ST_RECV: begin
          cap_q <= {cap_q[6:0], MISO};
          // publish the full byte on the same edge that enters ST_FIN
          if (bit_cnt == 4'd7) begin
            rdata_q  <= {cap_q[6:0], MISO};
            wait_cnt <= GAP_M1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        ST_FIN: wait_cnt <= wait_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_CHK;
        end
      end
      ST_CHK:   state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == 4'd9) state_nxt = rd_q ? ST_TURN : ST_FIN;
      ST_TURN:  if (wait_cnt == 4'd0) state_nxt = ST_RECV;
      ST_RECV:  if (bit_cnt == 4'd7) state_nxt = ST_FIN;
      ST_FIN: begin
        // last gap cycle may accept directly so chained frames see exactly GAP idle cycles
        if (wait_cnt == 4'd0) begin
          if (start) begin
            accept    = 1'b1;
            state_nxt = ST_CHK;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy        = (state != ST_IDLE);
  assign SS_n        = !((state == ST_CHK) || (state == ST_SHIFT) ||
                         (state == ST_TURN) || (state == ST_RECV));
  assign MOSI        = ((state == ST_CHK) || (state == ST_SHIFT)) && frame_q[9];
  assign done        = (state == ST_FIN) && (wait_cnt == GAP_M1);
  assign rdata_valid = done && rd_q;
  assign rdata       = rdata_q;

endmodule
